// File: rtl/vid_palette_lookup.sv
// vid_palette_lookup: palette index to RGBA stage behind a synchronous-read palette RAM.
//   Colour key: index 0 forces alpha to zero.
//   Optional feature macro VID_PAL_FADE_EN scales RGB by (fade+1)/256. Without it, RGB pass through.
//   Ports:
//     clk, reset              clock (also the RAM read clock) and sync active-high reset
//     in_valid/in_ready       input handshake for in_index, in_bank, in_last
//     out_valid/out_ready     output handshake for out_rgba {A,B,G,R} and out_last
//     fade                    global brightness, sampled when the output register loads
//     pal_addr/pal_en/pal_q   palette RAM read port (q valid the cycle after en)
module vid_palette_lookup (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_index,
  input  logic        in_bank,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_rgba,
  output logic        out_last,
  input  logic [7:0]  fade,
  output logic [8:0]  pal_addr,
  output logic        pal_en,
  input  logic [31:0] pal_q
);
  logic        r_s1_valid;
  logic        r_s1_last;
  logic        r_s1_key;
  logic        r_out_valid;
  logic        r_out_last;
  logic [31:0] r_out_rgba;
  logic        w_advance;
  logic [7:0]  w_a;
  logic [7:0]  w_b;
  logic [7:0]  w_g;
  logic [7:0]  w_r;
  // The whole pipeline, including the RAM output register, moves together,
  // so stalling the RAM clock enable is what keeps pal_q stable.
  assign w_advance = !r_out_valid || out_ready;
  assign in_ready  = w_advance || reset;
  assign pal_en    = w_advance && !reset;
  assign pal_addr  = {in_bank, in_index};
  assign w_a       = r_s1_key ? 8'h00 : pal_q[31:24];
`ifdef VID_PAL_FADE_EN
  logic [8:0] w_scale;
  assign w_scale = {1'b0, fade} + 9'd1;
  // 8x9 product, keep bits [15:8]; fade=255 is identity, fade=0 is black.
  assign w_b = 8'((16'(pal_q[23:16]) * 16'(w_scale)) >> 8);
  assign w_g = 8'((16'(pal_q[15:8])  * 16'(w_scale)) >> 8);
  assign w_r = 8'((16'(pal_q[7:0])   * 16'(w_scale)) >> 8);
`else
  logic w_unused_fade;
  assign w_unused_fade = ^fade;
  assign w_b = pal_q[23:16];
  assign w_g = pal_q[15:8];
  assign w_r = pal_q[7:0];
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_last   <= 1'b0;
      r_s1_key    <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_rgba  <= 32'h0;
    end else if (w_advance) begin
      r_s1_valid  <= in_valid;
      r_s1_last   <= in_last;
      r_s1_key    <= (in_index == 8'h00);
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_last;
      r_out_rgba  <= {w_a, w_b, w_g, w_r};
    end
  end
  assign out_valid = r_out_valid;
  assign out_last  = r_out_last;
  assign out_rgba  = r_out_rgba;
endmodule

// File: tb/tb_vid_palette_lookup.sv
// tb_vid_palette_lookup: directed bench for vid_palette_lookup with a palette RAM model.
module tb_vid_palette_lookup;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_index = 8'h0;
  logic        in_bank = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_rgba;
  logic        out_last;
  logic [7:0]  fade = 8'd255;
  logic [8:0]  pal_addr;
  logic        pal_en;
  logic [31:0] pal_q = 32'h0;
  logic [31:0] mem [0:511];
  typedef struct {
    logic [31:0] rgba;
    logic        last;
    int          cyc;
    bit          lat;
  } exp_t;
  exp_t        exp_q [$];
  logic [31:0] exp_rgba = 32'h0;
  logic        exp_last = 1'b0;
  bit          rnd = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_fail = 0;
  vid_palette_lookup dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_index(in_index), .in_bank(in_bank), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_rgba(out_rgba),
    .out_last(out_last), .fade(fade), .pal_addr(pal_addr), .pal_en(pal_en),
    .pal_q(pal_q)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pal_en) pal_q <= mem[pal_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  initial forever begin
    @(posedge clk);
    #1;
    out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
  end
  initial begin
    bit          p_stall = 1'b0;
    logic [31:0] p_rgba = 32'h0;
    logic        p_last = 1'b0;
    exp_t        e;
    forever begin
      @(negedge clk);
      if (reset) begin
        exp_q.delete();
        p_stall = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'h1);
        continue;
      end
      if (p_stall) begin
        check("hold_rgba", out_rgba, p_rgba);
        check("hold_last", 32'(out_last), 32'(p_last));
      end
      if (out_valid && !out_ready) check("stall_in_ready", 32'(in_ready), 32'h0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("extra_pixel", 32'(out_rgba), 32'hx);
        else begin
          e = exp_q.pop_front();
          check("rgba", out_rgba, e.rgba);
          check("last", 32'(out_last), 32'(e.last));
          if (e.lat) check("latency", 32'(cyc), 32'(e.cyc + 2));
        end
      end
      if (in_valid && in_ready) exp_q.push_back('{exp_rgba, exp_last, cyc, !rnd});
      p_stall = out_valid && !out_ready;
      p_rgba  = out_rgba;
      p_last  = out_last;
    end
  end
  task automatic push(input logic [8:0] a, input logic l, input logic [31:0] e);
    bit acc = 1'b0;
    int k = 0;
    in_index = a[7:0];
    in_bank  = a[8];
    in_last  = l;
    exp_rgba = e;
    exp_last = l;
    in_valid = 1'b1;
    while (!acc && k < 200) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      k++;
    end
    if (!acc) check("push_timeout", 32'h0, 32'h1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 400) begin
      idle(1);
      k++;
    end
    check("drain_left", 32'(exp_q.size()), 32'h0);
    idle(3);
  endtask
  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'h0;
    mem[9'h005] = 32'hFF112233;
    mem[9'h105] = 32'h80445566;
    mem[9'h000] = 32'hFFAABBCC;
    mem[9'h100] = 32'h7F010203;
    mem[9'h010] = 32'hFFC8FF00;
    for (int i = 0; i < 8; i++) mem[9'h020 + i] = 32'hC0A05000 + i;
    mem[9'h130] = 32'h01000001;
    mem[9'h131] = 32'h02000002;
    mem[9'h132] = 32'h03000003;
    mem[9'h133] = 32'h04000004;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'h0);
    check("rst_out_rgba", out_rgba, 32'h0);
    check("rst_out_last", 32'(out_last), 32'h0);
    check("rst_pal_en", 32'(pal_en), 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    push(9'h005, 1'b0, 32'hFF112233);
    push(9'h105, 1'b0, 32'h80445566);
    drain();
    push(9'h000, 1'b0, 32'h00AABBCC);
    push(9'h100, 1'b0, 32'h00010203);
    drain();
    rnd = 1'b1;
    for (int i = 0; i < 8; i++) push(9'h020 + 9'(i), 1'b0, 32'hC0A05000 + 32'(i));
    drain();
    rnd = 1'b0;
    idle(2);
    fade = 8'd128;
`ifdef VID_PAL_FADE_EN
    push(9'h010, 1'b0, 32'hFF648000);
`else
    push(9'h010, 1'b0, 32'hFFC8FF00);
`endif
    drain();
    fade = 8'd0;
`ifdef VID_PAL_FADE_EN
    push(9'h010, 1'b0, 32'hFF000000);
`else
    push(9'h010, 1'b0, 32'hFFC8FF00);
`endif
    drain();
    fade = 8'd255;
    push(9'h130, 1'b0, 32'h01000001);
    push(9'h131, 1'b0, 32'h02000002);
    idle(1);
    push(9'h132, 1'b0, 32'h03000003);
    push(9'h133, 1'b1, 32'h04000004);
    drain();
    push(9'h005, 1'b0, 32'hFF112233);
    push(9'h105, 1'b0, 32'h80445566);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_index = 8'h05;
    in_bank  = 1'b0;
    exp_rgba = 32'hDEADBEEF;
    @(negedge clk);
    check("midrst_pal_en", 32'(pal_en), 32'h0);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", 32'(out_valid), 32'h0);
    check("midrst_out_rgba", out_rgba, 32'h0);
    @(posedge clk);
    #1;
    push(9'h105, 1'b0, 32'h80445566);
    drain();
    idle(5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/vid_palette_lookup.md
# vid_palette_lookup

Pixel-stream palette stage sitting directly downstream of the video palette RAM's read port. Takes 8-bit palette indices plus a bank bit from the layer renderer, issues reads on the palette RAM's synchronous read port, and emits 32-bit RGBA pixels to the compositor over a valid/ready handshake. Applies colour-key transparency and an optional global fade. The stall-all pipeline uses the RAM clock-enable so that read data is held under backpressure.

## Interface
- No parameters.

Ports:
- clk  in  1  system clock; also clocks the palette RAM read port
- reset  in  1  synchronous, active-high
- in_valid  in  1  input pixel present
- in_ready  out  1  input pixel accepted this cycle when in_valid && in_ready
- in_index  in  8  palette index
- in_bank  in  1  palette bank; RAM address = {in_bank, in_index}
- in_last  in  1  last pixel of line; passed through unchanged
- out_valid  out  1  output pixel present
- out_ready  in  1  downstream accepts when out_valid && out_ready
- out_rgba  out  32  [31:24]=A, [23:16]=B, [15:8]=G, [7:0]=R
- out_last  out  1  delayed in_last
- fade  in  8  global brightness; sampled at output capture
- pal_addr  out  9  to RAM read-port address
- pal_en  out  1  to RAM read-port clock enable
- pal_q  in  32  RAM read data, valid the cycle after pal_en with address

## Operation
- Two stages:
  - S1: RAM output register, plus the s1_valid, s1_last and s1_key flags.
  - S2: output register.
- advance = !out_valid || out_ready (combinational).
- in_ready = advance. This is a combinational path from out_ready; it is intentional.
- pal_en = advance && !reset. pal_addr = {in_bank, in_index} (combinational).
- On advance:
  - s1_valid <= in_valid.
  - s1_last <= in_last.
  - s1_key <= (in_index == 0).
  - out_valid <= s1_valid.
  - out_last <= s1_last.
  - out_rgba <= f(pal_q).
- When advance is low, all registers hold, and the RAM holds QB because its clock enable is low.
- Colour key: if s1_key, A = 0, and RGB come from the palette unchanged. Otherwise A = pal_q[31:24].
- When out_valid is captured as 0, out_rgba is still loaded. Its value is don't-care but deterministic.
- Reset takes priority over everything:
  - out_valid, s1_valid, out_last and s1_last = 0.
  - out_rgba = 32'h0.
  - in_ready = 1 during reset; inputs offered during reset are dropped.
  - In-flight pixels are discarded when reset is asserted mid-stream.

## Timing
- Latency: a pixel accepted in cycle N appears on out_valid in cycle N+2 if there is no stall.
- Throughput: 1 pixel/clk while out_ready = 1.
- Stall: out_ready = 0 with out_valid = 1 freezes the whole pipeline. out_rgba and out_last stay stable until accepted.
- Bubbles: in_valid = 0 cycles propagate as out_valid = 0 cycles. They cost no extra latency.
- Simultaneous out accept and in accept in the same cycle is legal; there is no lost or duplicated pixel.
- Palette writes on the other RAM port that hit the address being read follow the RAM's read-before-write semantics. This block does not arbitrate them.

## Configuration
- VID_PAL_FADE_EN defined:
  - Each of R, G, B becomes (c * (fade + 1)) >> 8, using an 8x9-bit product with result bits [15:8].
  - fade = 255 gives identity; fade = 0 gives black.
  - Alpha is never faded.
  - fade is sampled on the advance edge that loads S2.
- VID_PAL_FADE_EN undefined:
  - RGB pass through from pal_q.
  - The fade port is present but ignored, and no multipliers are synthesised.
- Latency is 2 cycles in both builds.

## Test plan
- Streaming:
  - Stimulus: preload RAM[0x005] = 0xFF112233 and RAM[0x105] = 0x80445566; stream index 5 with bank 0 and then bank 1, out_ready = 1, fade = 255.
  - Required: out_rgba = 0xFF112233 then 0x80445566, exactly 2 cycles after each accept.
- Colour key:
  - Stimulus: RAM[0x000] = 0xFFAABBCC; send index 0.
  - Required: out_rgba = 0x00AABBCC.
- Backpressure:
  - Stimulus: stream 8 sequential indices with out_ready toggled randomly.
  - Required: all 8 pixels emitted in order with no drop or duplicate; out_rgba stable while out_valid && !out_ready; in_ready = 0 whenever out_valid && !out_ready.
- Fade (VID_PAL_FADE_EN):
  - Stimulus: RAM entry 0xFFC8FF00 (R = 0x00, G = 0xFF, B = 0xC8); fade = 128.
  - Required: out_rgba = 0xFF648000, i.e. B = 200*129 >> 8 = 100, G = 255*129 >> 8 = 128, R = 0, A = 0xFF unchanged.
  - Additional stimulus: fade = 0.
  - Required: out_rgba = 0xFF000000.
- Line marker:
  - Stimulus: send 4 pixels with in_last = 1 on the 4th, with a 1-cycle bubble between pixels 2 and 3.
  - Required: out_last = 1 only with the 4th output pixel, and one out_valid = 0 gap is reproduced.
- Reset mid-stream:
  - Stimulus: assert reset for 1 cycle with 2 pixels in flight.
  - Required: next cycle out_valid = 0 and out_rgba = 0; no stale pixel ever appears afterwards; the first post-reset pixel emerges 2 cycles after acceptance.
